// File: rtl/aes_dec_round_ctrl.sv
// Round sequencer for the iterative AES-128 inverse cipher: key index NR..0, one dp_go per round.
// Latency 1 + (NR+1)*(1+L) cycles accept->done for datapath ack latency L; dp_ack stalls the sequence indefinitely.
// Optional macro AES_DEC_TIMEOUT_EN adds a dp_ack watchdog (TIMEOUT cycles) with a sticky err flag.
module aes_dec_round_ctrl #(
  parameter int NR      = 10,
  parameter int KAW     = 4,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           key_vld,
  input  logic           abort,
  input  logic           dp_ack,
  output logic           dp_go,
  output logic [1:0]     dp_op,
  output logic [KAW-1:0] key_addr,
  output logic           busy,
  output logic           done,
  output logic           err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_WAIT  = 3'd2,
    S_ROUND = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  localparam logic [1:0]     OP_ADDKEY = 2'b00;
  localparam logic [1:0]     OP_FULL   = 2'b01;
  localparam logic [1:0]     OP_LAST   = 2'b10;
  localparam logic [KAW-1:0] NR_K      = KAW'(NR);

  if (((2 ** KAW) <= NR) || (TIMEOUT < 1)) begin : g_bad_param
    $error("aes_dec_round_ctrl: KAW too narrow for NR or TIMEOUT < 1");
  end

  state_t         state, state_nxt;
  logic [KAW-1:0] r;
  logic           accept;
  logic           ack_hit;
  logic           timeout_hit;

  assign accept  = (state == S_IDLE) && start && key_vld && !abort;
  assign ack_hit = (state == S_WAIT) && dp_ack && !abort;

`ifdef AES_DEC_TIMEOUT_EN
  localparam int WCW = $clog2(TIMEOUT + 1);
  logic [WCW-1:0] wait_cnt;
  logic           err_q;

  // Counter rests at zero outside WAIT, so it is already clear on WAIT entry.
  assign timeout_hit = (state == S_WAIT) && !dp_ack && (wait_cnt == WCW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state != S_WAIT)
        wait_cnt <= '0;
      else if (!dp_ack)
        wait_cnt <= wait_cnt + 1'b1;

      if (accept || abort)
        err_q <= 1'b0;
      else if (state_nxt == S_ERR)
        err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_comb begin
    state_nxt = S_IDLE;
    dp_go     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE:  state_nxt = accept ? S_INIT : S_IDLE;
      S_INIT: begin
        state_nxt = S_WAIT;
        dp_go     = 1'b1;
        busy      = 1'b1;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (dp_ack)
          state_nxt = (r == '0) ? S_DONE : S_ROUND;
        else if (timeout_hit)
          state_nxt = S_ERR;
        else
          state_nxt = S_WAIT;
      end
      S_ROUND: begin
        state_nxt = S_WAIT;
        dp_go     = 1'b1;
        busy      = 1'b1;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        done      = 1'b1;
      end
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (abort)
      state_nxt = S_IDLE;
  end

  // key_addr/dp_op change only on the edge entering INIT or ROUND, so they hold through WAIT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      r        <= '0;
      key_addr <= '0;
      dp_op    <= OP_ADDKEY;
    end else begin
      state <= state_nxt;
      if (accept) begin
        r        <= NR_K;
        key_addr <= NR_K;
        dp_op    <= OP_ADDKEY;
      end else if (ack_hit && (r != '0)) begin
        r        <= r - KAW'(1);
        key_addr <= r - KAW'(1);
        dp_op    <= (r == KAW'(1)) ? OP_LAST : OP_FULL;
      end
    end
  end

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// Bench for aes_dec_round_ctrl: randomized ack latencies checked against an op-list reference model.
`timescale 1ns/1ps
module tb_aes_dec_round_ctrl;
  localparam int NR      = 10;
  localparam int KAW     = 4;
  localparam int TIMEOUT = 64;

  logic           clk = 1'b0;
  logic           rst_n, start, key_vld, abort, dp_ack;
  logic           dp_go;
  logic [1:0]     dp_op;
  logic [KAW-1:0] key_addr;
  logic           busy, done, err;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int lats[$];

  aes_dec_round_ctrl #(.NR(NR), .KAW(KAW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_vld(key_vld), .abort(abort),
    .dp_ack(dp_ack), .dp_go(dp_go), .dp_op(dp_op), .key_addr(key_addr),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Reference model: i-th op of a decryption uses key NR-i; first ADDKEY, last LAST, rest FULL.
  function automatic int exp_key(input int i);
    return NR - i;
  endfunction

  function automatic logic [1:0] exp_op(input int i);
    if (i == 0)  return 2'b00;
    if (i == NR) return 2'b10;
    return 2'b01;
  endfunction

  function automatic int exp_done_cycle();
    int t = 1;
    foreach (lats[i]) t += 1 + lats[i];
    return t;
  endfunction

  // mode 0: L=1, mode 1: 1,5,2,7 cycling, mode 2: random 1..6
  task automatic run_seq(input string tag, input int mode, input bit stray,
                         input bit hold_start, input int abort_key);
    int gi, ack_at, abort_at, done_k, busy_n, go_err, err_n, extra;
    bit aborted;
    lats.delete();
    for (int i = 0; i <= NR; i++) begin
      case (mode)
        0: lats.push_back(1);
        1: case (i % 4) 0: lats.push_back(1); 1: lats.push_back(5);
                        2: lats.push_back(2); default: lats.push_back(7); endcase
        default: lats.push_back(int'($urandom_range(1, 6)));
      endcase
    end
    gi = 0; ack_at = -1; abort_at = -1; done_k = -1; busy_n = 0; go_err = 0; err_n = 0;
    aborted = 1'b0;
    @(negedge clk); key_vld = 1'b1; start = 1'b1; dp_ack = 1'b0; abort = 1'b0;
    @(negedge clk); if (!hold_start) start = 1'b0;
    for (int k = 1; k <= 1000 && done_k < 0 && !aborted; k++) begin
      if (k > 1) @(negedge clk);
      busy_n += int'(busy);
      err_n  += int'(err);
      if (dp_go) begin
        if (gi > NR || key_addr !== KAW'(exp_key(gi)) || dp_op !== exp_op(gi)) go_err++;
        ack_at = k + ((gi <= NR) ? lats[gi] : 1);
        if (abort_key == int'(key_addr)) abort_at = ack_at;
        gi++;
      end
      dp_ack = (k == ack_at) || (stray && dp_go);
      if (k == abort_at) begin abort = 1'b1; aborted = 1'b1; end
      if (done) done_k = k;
    end
    if (aborted) begin
      @(negedge clk); abort = 1'b0; dp_ack = 1'b0;
      chk_cnt++;
      if ({busy, dp_go, done} !== 3'b000)
        $display("FAIL %s abort_idle: busy/go/done=%b expected 000", tag, {busy, dp_go, done});
      else pass_cnt++;
      extra = 0;
      repeat (30) begin @(negedge clk); extra += int'(dp_go) + int'(done) + int'(busy); end
      chk_cnt++;
      if (extra !== 0) $display("FAIL %s abort_quiet: activity=%0d expected 0", tag, extra);
      else pass_cnt++;
    end else begin
      dp_ack = 1'b0;
      chk_cnt++;
      if (gi !== NR + 1) $display("FAIL %s go_count: got %0d expected %0d", tag, gi, NR + 1);
      else pass_cnt++;
      chk_cnt++;
      if (go_err !== 0) $display("FAIL %s go_seq: bad key/op ops=%0d expected 0", tag, go_err);
      else pass_cnt++;
      chk_cnt++;
      if (done_k !== exp_done_cycle())
        $display("FAIL %s done_time: got %0d expected %0d", tag, done_k, exp_done_cycle());
      else pass_cnt++;
      chk_cnt++;
      if (busy_n !== exp_done_cycle() - 1)
        $display("FAIL %s busy_len: got %0d expected %0d", tag, busy_n, exp_done_cycle() - 1);
      else pass_cnt++;
      chk_cnt++;
      if (err_n !== 0) $display("FAIL %s err_seen: got %0d expected 0", tag, err_n);
      else pass_cnt++;
      @(negedge clk);
      chk_cnt++;
      if ({done, busy} !== 2'b00)
        $display("FAIL %s after_done: done/busy=%b expected 00", tag, {done, busy});
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; key_vld = 1'b1; abort = 1'b0; dp_ack = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk_cnt++;
      if ({dp_go, dp_op, key_addr, busy, done, err} !== '0)
        $display("FAIL reset_outputs: got %b expected 0", {dp_go, dp_op, key_addr, busy, done, err});
      else pass_cnt++;
    end
    start = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_nominal();
    run_seq("nominal", 0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_variable_latency();
    int act = 0;
    dp_ack = 1'b1;
    repeat (3) begin @(negedge clk); act += int'(busy) + int'(dp_go); end
    dp_ack = 1'b0;
    chk_cnt++;
    if (act !== 0) $display("FAIL idle_stray_ack: activity=%0d expected 0", act);
    else pass_cnt++;
    run_seq("varlat", 1, 1'b1, 1'b0, -1);
    repeat (3) run_seq("random", 2, 1'b0, 1'b0, -1);
  endtask

  task automatic test_gating();
    int act = 0;
    @(negedge clk); key_vld = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) begin @(negedge clk); act += int'(busy) + int'(dp_go); end
    chk_cnt++;
    if (act !== 0) $display("FAIL gate_keyvld: activity=%0d expected 0", act);
    else pass_cnt++;
    act = 0;
    key_vld = 1'b1; start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    repeat (5) begin @(negedge clk); act += int'(busy) + int'(dp_go); end
    chk_cnt++;
    if (act !== 0) $display("FAIL gate_abort_start: activity=%0d expected 0", act);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    run_seq("held_start", 2, 1'b0, 1'b1, -1);
    @(negedge clk);
    chk_cnt++;
    if (busy !== 1'b1) $display("FAIL reaccept: busy=%b expected 1", busy);
    else pass_cnt++;
    start = 1'b0; abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL cleanup_abort: busy=%b expected 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    run_seq("abort", 0, 1'b0, 1'b0, 8);
    run_seq("restart", 2, 1'b0, 1'b0, -1);
  endtask

  task automatic test_reset_mid();
    int act = 0;
    @(negedge clk); start = 1'b1; key_vld = 1'b1; dp_ack = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; dp_ack = 1'b0;
    chk_cnt++;
    if ({dp_go, dp_op, key_addr, busy, done, err} !== '0)
      $display("FAIL reset_mid: got %b expected 0", {dp_go, dp_op, key_addr, busy, done, err});
    else pass_cnt++;
    repeat (5) begin @(negedge clk); act += int'(busy) + int'(dp_go) + int'(done); end
    chk_cnt++;
    if (act !== 0) $display("FAIL reset_mid_quiet: activity=%0d expected 0", act);
    else pass_cnt++;
  endtask

`ifdef AES_DEC_TIMEOUT_EN
  task automatic test_timeout();
    int gn = 0, ack_at = -1, g3 = -1, err_k = -1, done_n = 0;
    bit busy_at_err = 1'b1;
    @(negedge clk); start = 1'b1; key_vld = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 1; k <= 300 && err_k < 0; k++) begin
      if (k > 1) @(negedge clk);
      if (dp_go) begin
        gn++;
        if (gn < 3) ack_at = k + 1; else g3 = k;
      end
      dp_ack = (k == ack_at);
      done_n += int'(done);
      if (err) begin err_k = k; busy_at_err = busy; end
    end
    dp_ack = 1'b0;
    chk_cnt++;
    if (err_k !== g3 + TIMEOUT + 1)
      $display("FAIL timeout_time: err at %0d expected %0d", err_k, g3 + TIMEOUT + 1);
    else pass_cnt++;
    chk_cnt++;
    if ({busy_at_err, done_n[0]} !== 2'b00)
      $display("FAIL timeout_state: busy=%b done_n=%0d expected 0/0", busy_at_err, done_n);
    else pass_cnt++;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk_cnt++;
    if ({err, busy} !== 2'b01) $display("FAIL timeout_clear: err/busy=%b expected 01", {err, busy});
    else pass_cnt++;
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
  endtask
`endif

  initial begin
    rst_n = 1'b0; start = 1'b0; key_vld = 1'b0; abort = 1'b0; dp_ack = 1'b0;
    test_reset();
    test_nominal();
    test_variable_latency();
    test_gating();
    test_back_to_back();
    test_abort();
    test_reset_mid();
`ifdef AES_DEC_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
